// File: rtl/booth_pkg.sv
// Shared types for the Booth multiplier arbiter: FSM states, default operand width, product width helper.
package booth_pkg;

   localparam int W_DEF = 4;

   typedef enum logic [1:0] {
      IDLE,
      WAIT,
      DONE
   } state_t;

   function automatic int prod_w(input int w);
      return 2 * w;
   endfunction

endpackage

// File: rtl/booth_mul_arbiter_if.sv
// Client and multiplier bundle for booth_mul_arbiter; slave is the arbiter, master is the environment.
interface booth_mul_arbiter_if #(
   parameter int NREQ = 4,
   parameter int W    = booth_pkg::W_DEF
) ();
   logic [NREQ-1:0]                 req;
   logic [NREQ*W-1:0]               a_in;
   logic [NREQ*W-1:0]               b_in;
   logic [NREQ-1:0]                 gnt;
   logic [NREQ-1:0]                 done;
   logic [booth_pkg::prod_w(W)-1:0] result;
   logic                            err;
   logic                            busy;
   logic                            mul_start;
   logic [W-1:0]                    mul_a;
   logic [W-1:0]                    mul_b;
   logic                            mul_valid;
   logic [booth_pkg::prod_w(W)-1:0] mul_c;

   modport slave (
      input  req, a_in, b_in, mul_valid, mul_c,
      output gnt, done, result, err, busy, mul_start, mul_a, mul_b
   );

   modport master (
      output req, a_in, b_in, mul_valid, mul_c,
      input  gnt, done, result, err, busy, mul_start, mul_a, mul_b
   );
endinterface

// File: rtl/rr_pick.sv
// Combinational round-robin picker: first set request at or above ptr, wrapping; zero latency.
module rr_pick #(
   parameter int NREQ = 4
) (
   input  logic [NREQ-1:0]         req,
   input  logic [$clog2(NREQ)-1:0] ptr,
   output logic [NREQ-1:0]         gnt_oh,
   output logic [$clog2(NREQ)-1:0] owner,
   output logic                    any_req
);
   localparam int IW = $clog2(NREQ);

   function automatic logic [IW-1:0] wrap_idx(input int v);
      return (v >= NREQ) ? IW'(v - NREQ) : IW'(v);
   endfunction

   // Scanning downward lets the closest request to ptr overwrite farther ones.
   always_comb begin
      owner   = '0;
      any_req = 1'b0;
      for (int i = NREQ - 1; i >= 0; i--) begin
         if (req[wrap_idx(int'(ptr) + i)]) begin
            owner   = wrap_idx(int'(ptr) + i);
            any_req = 1'b1;
         end
      end
      gnt_oh = any_req ? (NREQ'(1) << owner) : '0;
   end
endmodule

// File: rtl/booth_mul_arbiter.sv
// Shares one iterative Booth multiplier among NREQ clients, round-robin; grant 1 cycle after request,
// done 1 cycle after mul_valid or after TIMEOUT wait cycles; clients hold req until done.
module booth_mul_arbiter
   import booth_pkg::*;
#(
   parameter int NREQ    = 4,
   parameter int W       = W_DEF,
   parameter int TIMEOUT = 16
) (
   input logic                clk,
   input logic                reset,
   booth_mul_arbiter_if.slave bus
);
   localparam int IW = $clog2(NREQ);
   localparam int CW = $clog2(TIMEOUT);
   localparam int PW = prod_w(W);

   state_t          state_q, state_n;
   logic [IW-1:0]   ptr_q, ptr_n;
   logic [IW-1:0]   owner_q, owner_n;
   logic [CW-1:0]   cnt_q, cnt_n;
   logic [NREQ-1:0] gnt_q, gnt_n;
   logic [NREQ-1:0] done_q, done_n;
   logic            err_q, err_n;
   logic            start_q, start_n;
   logic [W-1:0]    a_q, a_n;
   logic [W-1:0]    b_q, b_n;
   logic [PW-1:0]   res_q, res_n;

   logic [NREQ-1:0] pick_oh;
   logic [IW-1:0]   pick_owner;
   logic            pick_any;

   rr_pick #(.NREQ(NREQ)) u_pick (
      .req     (bus.req),
      .ptr     (ptr_q),
      .gnt_oh  (pick_oh),
      .owner   (pick_owner),
      .any_req (pick_any)
   );

   always_comb begin
      state_n = state_q;
      ptr_n   = ptr_q;
      owner_n = owner_q;
      cnt_n   = cnt_q;
      gnt_n   = '0;
      done_n  = '0;
      err_n   = 1'b0;
      start_n = 1'b0;
      a_n     = a_q;
      b_n     = b_q;
      res_n   = res_q;
      case (state_q)
         IDLE: begin
            if (pick_any) begin
               gnt_n   = pick_oh;
               start_n = 1'b1;
               owner_n = pick_owner;
               a_n     = bus.a_in[int'(pick_owner) * W +: W];
               b_n     = bus.b_in[int'(pick_owner) * W +: W];
               cnt_n   = '0;
               state_n = WAIT;
            end
         end
         WAIT: begin
            cnt_n = cnt_q + 1'b1;
            // A product arriving on the final wait cycle still beats the timeout.
            if (bus.mul_valid) begin
               res_n   = bus.mul_c;
               done_n  = NREQ'(1) << owner_q;
               state_n = DONE;
            end else if (cnt_q == CW'(TIMEOUT - 1)) begin
               res_n   = '0;
               done_n  = NREQ'(1) << owner_q;
               err_n   = 1'b1;
               state_n = DONE;
            end
         end
         DONE: begin
            ptr_n   = (owner_q == IW'(NREQ - 1)) ? '0 : owner_q + 1'b1;
            state_n = IDLE;
         end
         default: state_n = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q <= IDLE;
         ptr_q   <= '0;
         owner_q <= '0;
         cnt_q   <= '0;
         gnt_q   <= '0;
         done_q  <= '0;
         err_q   <= 1'b0;
         start_q <= 1'b0;
         a_q     <= '0;
         b_q     <= '0;
         res_q   <= '0;
      end else begin
         state_q <= state_n;
         ptr_q   <= ptr_n;
         owner_q <= owner_n;
         cnt_q   <= cnt_n;
         gnt_q   <= gnt_n;
         done_q  <= done_n;
         err_q   <= err_n;
         start_q <= start_n;
         a_q     <= a_n;
         b_q     <= b_n;
         res_q   <= res_n;
      end
   end

   assign bus.gnt       = gnt_q;
   assign bus.done      = done_q;
   assign bus.err       = err_q;
   assign bus.mul_start = start_q;
   assign bus.mul_a     = a_q;
   assign bus.mul_b     = b_q;
   assign bus.result    = res_q;
   assign bus.busy      = (state_q != IDLE);
endmodule

// File: tb/tb_booth_mul_arbiter.sv
// Scoreboard bench for booth_mul_arbiter with a behavioural multiplier of programmable latency.
module tb_booth_mul_arbiter;
   localparam int NREQ    = 4;
   localparam int W       = 4;
   localparam int TIMEOUT = 16;

   typedef struct {
      int         idx;
      logic [3:0] a;
      logic [3:0] b;
   } gnt_exp_t;

   typedef struct {
      int         idx;
      logic [7:0] res;
      logic       err;
      int         dly;
   } done_exp_t;

   logic clk = 1'b0;
   logic reset;
   always #5 clk = ~clk;

   booth_mul_arbiter_if #(.NREQ(NREQ), .W(W)) bus ();

   booth_mul_arbiter #(.NREQ(NREQ), .W(W), .TIMEOUT(TIMEOUT)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   gnt_exp_t  gq[$];
   done_exp_t dq[$];
   int checks = 0;
   int failures = 0;
   int cyc = 0;
   int mdl_lat = 4;
   int mdl_skip_total = 0;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: actual=%0h required=%0h", name, act, exp);
      end
   endtask

   // Multiplier stand-in: valid arrives mdl_lat cycles after the start cycle; skipped starts never complete.
   initial begin : model
      int skipped = 0;
      logic signed [7:0] prod;
      bus.mul_valid = 1'b0;
      bus.mul_c     = '0;
      forever begin
         @(posedge clk);
         #1;
         if (bus.mul_start) begin
            if (skipped < mdl_skip_total) begin
               skipped++;
               bus.mul_c = 8'h5A;
            end else begin
               prod = $signed({{4{bus.mul_a[3]}}, bus.mul_a}) * $signed({{4{bus.mul_b[3]}}, bus.mul_b});
               repeat (mdl_lat) @(posedge clk);
               #1;
               bus.mul_valid = 1'b1;
               bus.mul_c     = prod;
               @(posedge clk);
               #1;
               bus.mul_valid = 1'b0;
            end
         end
      end
   end

   initial begin : monitor
      int g_cyc = 0;
      gnt_exp_t  ge;
      done_exp_t de;
      forever begin
         @(negedge clk);
         if (bus.gnt != '0) begin
            g_cyc = cyc;
            if (gq.size() == 0) chk("gnt_unexpected", 32'(bus.gnt), 32'd0);
            else begin
               ge = gq.pop_front();
               chk("gnt_onehot", 32'(bus.gnt), 32'(1) << ge.idx);
               chk("gnt_mul_a", 32'(bus.mul_a), 32'(ge.a));
               chk("gnt_mul_b", 32'(bus.mul_b), 32'(ge.b));
               chk("gnt_mul_start", 32'(bus.mul_start), 32'd1);
               chk("gnt_busy", 32'(bus.busy), 32'd1);
            end
         end
         if (bus.done != '0) begin
            if (dq.size() == 0) chk("done_unexpected", 32'(bus.done), 32'd0);
            else begin
               de = dq.pop_front();
               chk("done_onehot", 32'(bus.done), 32'(1) << de.idx);
               chk("done_result", 32'(bus.result), 32'(de.res));
               chk("done_err", 32'(bus.err), 32'(de.err));
               chk("done_latency", 32'(cyc - g_cyc), 32'(de.dly));
            end
         end else if (bus.err) begin
            chk("err_without_done", 32'(bus.err), 32'd0);
         end
      end
   end

   task automatic set_op(input int i, input logic [3:0] a, input logic [3:0] b);
      bus.a_in[i*W +: W] = a;
      bus.b_in[i*W +: W] = b;
   endtask

   task automatic expect_op(input int i, input logic [3:0] a, input logic [3:0] b,
                            input logic [7:0] res, input logic err, input int dly);
      gq.push_back('{i, a, b});
      dq.push_back('{i, res, err, dly});
   endtask

   // Waits for n done pulses; a requester in hold re-requests once with new operands.
   task automatic run(input int n, input logic [3:0] hold, input logic [3:0] na, input logic [3:0] nb);
      int got = 0;
      int budget = 0;
      logic [3:0] h = hold;
      while (got < n && budget < 300) begin
         @(negedge clk);
         budget++;
         if (bus.done != '0) begin
            got++;
            for (int i = 0; i < NREQ; i++) begin
               if (bus.done[i]) begin
                  if (h[i]) begin
                     h[i] = 1'b0;
                     set_op(i, na, nb);
                  end else begin
                     bus.req[i] = 1'b0;
                  end
               end
            end
         end
      end
      chk("run_done_count", 32'(got), 32'(n));
   endtask

   task automatic chk_all_zero(input string tag);
      chk({tag, "_gnt"}, 32'(bus.gnt), 32'd0);
      chk({tag, "_done"}, 32'(bus.done), 32'd0);
      chk({tag, "_err"}, 32'(bus.err), 32'd0);
      chk({tag, "_busy"}, 32'(bus.busy), 32'd0);
      chk({tag, "_mul_start"}, 32'(bus.mul_start), 32'd0);
      chk({tag, "_mul_a"}, 32'(bus.mul_a), 32'd0);
      chk({tag, "_mul_b"}, 32'(bus.mul_b), 32'd0);
      chk({tag, "_result"}, 32'(bus.result), 32'd0);
   endtask

   initial begin : stim
      int b;
      bus.req  = '0;
      bus.a_in = '0;
      bus.b_in = '0;
      reset    = 1'b1;
      #2 reset = 1'b0;
      repeat (3) @(negedge clk);
      chk_all_zero("reset");
      reset = 1'b1;
      @(negedge clk);

      // Single request: 3 * -2 = -6
      set_op(2, 4'h3, 4'hE);
      expect_op(2, 4'h3, 4'hE, 8'hFA, 1'b0, 5);
      bus.req[2] = 1'b1;
      run(1, 4'b0000, 4'h0, 4'h0);

      // -8 * -8 = 64, moves the pointer back to 0
      set_op(3, 4'h8, 4'h8);
      expect_op(3, 4'h8, 4'h8, 8'h40, 1'b0, 5);
      bus.req[3] = 1'b1;
      run(1, 4'b0000, 4'h0, 4'h0);

      // All four held; requester 0 keeps req up once and must wait behind 1..3
      set_op(0, 4'h7, 4'h8);
      set_op(1, 4'h0, 4'hB);
      set_op(2, 4'hD, 4'h5);
      set_op(3, 4'hF, 4'hF);
      expect_op(0, 4'h7, 4'h8, 8'hC8, 1'b0, 5);
      expect_op(1, 4'h0, 4'hB, 8'h00, 1'b0, 5);
      expect_op(2, 4'hD, 4'h5, 8'hF1, 1'b0, 5);
      expect_op(3, 4'hF, 4'hF, 8'h01, 1'b0, 5);
      expect_op(0, 4'h2, 4'h3, 8'h06, 1'b0, 5);
      bus.req = 4'b1111;
      run(5, 4'b0001, 4'h2, 4'h3);

      repeat (5) @(negedge clk);
      chk("result_hold", 32'(bus.result), 32'h06);
      chk("idle_busy", 32'(bus.busy), 32'd0);

      // Timeout on requester 1, then requester 2 served normally: 2 * -1 = -2
      mdl_skip_total = 1;
      set_op(1, 4'h1, 4'h1);
      set_op(2, 4'h2, 4'hF);
      expect_op(1, 4'h1, 4'h1, 8'h00, 1'b1, TIMEOUT);
      expect_op(2, 4'h2, 4'hF, 8'hFE, 1'b0, 5);
      bus.req = 4'b0110;
      run(2, 4'b0000, 4'h0, 4'h0);

      // Valid on the final wait cycle: 6 * -7 = -42, no error
      mdl_lat = TIMEOUT - 1;
      set_op(1, 4'h6, 4'h9);
      expect_op(1, 4'h6, 4'h9, 8'hD6, 1'b0, TIMEOUT);
      bus.req[1] = 1'b1;
      run(1, 4'b0000, 4'h0, 4'h0);
      mdl_lat = 4;

      // Reset while requester 3 waits; pointer (now 2) must return to 0
      mdl_skip_total = 2;
      set_op(3, 4'h4, 4'h4);
      gq.push_back('{3, 4'h4, 4'h4});
      bus.req = 4'b1000;
      b = 0;
      while (!bus.busy && b < 20) begin
         @(negedge clk);
         b++;
      end
      chk("abort_granted", 32'(bus.busy), 32'd1);
      repeat (3) @(negedge clk);
      reset = 1'b0;
      #1;
      chk_all_zero("abort");
      bus.req = '0;
      repeat (4) @(negedge clk);
      reset = 1'b1;
      set_op(0, 4'h5, 4'hD);
      set_op(3, 4'h8, 4'h1);
      expect_op(0, 4'h5, 4'hD, 8'hF1, 1'b0, 5);
      expect_op(3, 4'h8, 4'h1, 8'hF8, 1'b0, 5);
      bus.req = 4'b1001;
      run(2, 4'b0000, 4'h0, 4'h0);

      repeat (5) @(negedge clk);
      chk("gnt_queue_empty", 32'(gq.size()), 32'd0);
      chk("done_queue_empty", 32'(dq.size()), 32'd0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
